// File: rtl/alu_exec_unit.sv
// RV32I integer execution unit: takes one issued instruction per cycle from the
// reservation station and broadcasts its ALU, branch or jump result one cycle later.

package alu_exec_pkg;
    // Operation encoding on FU_op. Any value not listed is treated as an unknown op.
    localparam int OP_ADD   = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_SLL   = 3;
    localparam int OP_SLT   = 4;
    localparam int OP_SLTU  = 5;
    localparam int OP_XOR   = 6;
    localparam int OP_SRL   = 7;
    localparam int OP_SRA   = 8;
    localparam int OP_OR    = 9;
    localparam int OP_AND   = 10;
    localparam int OP_ADDI  = 11;
    localparam int OP_SLTI  = 12;
    localparam int OP_SLTIU = 13;
    localparam int OP_XORI  = 14;
    localparam int OP_ORI   = 15;
    localparam int OP_ANDI  = 16;
    localparam int OP_SLLI  = 17;
    localparam int OP_SRLI  = 18;
    localparam int OP_SRAI  = 19;
    localparam int OP_LUI   = 20;
    localparam int OP_AUIPC = 21;
    localparam int OP_JAL   = 22;
    localparam int OP_JALR  = 23;
    localparam int OP_BEQ   = 24;
    localparam int OP_BNE   = 25;
    localparam int OP_BLT   = 26;
    localparam int OP_BGE   = 27;
    localparam int OP_BLTU  = 28;
    localparam int OP_BGEU  = 29;
endpackage

// Handshake: FU_enable is a valid strobe with no ready; an instruction is taken on
// any edge where FU_enable=1, rdy=1 and jump_flag=0, and its result is presented
// with exc_valid=1 for exactly the following cycle. Consumers cannot stall it.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int OP_LOG  = 6,
    parameter int ROB_LOG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               jump_flag,
    input  logic               FU_enable,
    input  logic [OP_LOG-1:0]  FU_op,
    input  logic [31:0]        FU_Vj,
    input  logic [31:0]        FU_Vk,
    input  logic [31:0]        FU_Imm,
    input  logic [ROB_LOG-1:0] FU_DestRob,
    input  logic [31:0]        FU_CurPC,
    output logic               exc_valid,
    output logic [ROB_LOG-1:0] exc_RobId,
    output logic [31:0]        exc_value,
    output logic               exc_jump,
    output logic [31:0]        exc_target
);

    typedef enum logic [3:0] {
        FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU,
        FN_XOR, FN_SRL, FN_SRA, FN_OR, FN_AND, FN_PASS_B
    } alu_fn_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_BAD
    } op_class_t;

    typedef enum logic [2:0] {
        BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } br_cond_t;

    alu_fn_t   alu_fn;
    op_class_t op_class;
    br_cond_t  br_cond;
    logic      use_imm;

    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_out;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_sum;
    logic        br_eq;
    logic        br_lt_s;
    logic        br_lt_u;
    logic        br_taken;

    logic [31:0] nxt_value;
    logic        nxt_jump;
    logic [31:0] nxt_target;

    // Decode the op into an operation class, ALU function and operand select.
    always_comb begin
        alu_fn   = FN_ADD;
        op_class = CLS_BAD;
        br_cond  = BR_EQ;
        use_imm  = 1'b0;
        case (int'(FU_op))
            OP_ADD:   begin op_class = CLS_ALU; alu_fn = FN_ADD;  end
            OP_SUB:   begin op_class = CLS_ALU; alu_fn = FN_SUB;  end
            OP_SLL:   begin op_class = CLS_ALU; alu_fn = FN_SLL;  end
            OP_SLT:   begin op_class = CLS_ALU; alu_fn = FN_SLT;  end
            OP_SLTU:  begin op_class = CLS_ALU; alu_fn = FN_SLTU; end
            OP_XOR:   begin op_class = CLS_ALU; alu_fn = FN_XOR;  end
            OP_SRL:   begin op_class = CLS_ALU; alu_fn = FN_SRL;  end
            OP_SRA:   begin op_class = CLS_ALU; alu_fn = FN_SRA;  end
            OP_OR:    begin op_class = CLS_ALU; alu_fn = FN_OR;   end
            OP_AND:   begin op_class = CLS_ALU; alu_fn = FN_AND;  end
            OP_ADDI:  begin op_class = CLS_ALU; alu_fn = FN_ADD;  use_imm = 1'b1; end
            OP_SLTI:  begin op_class = CLS_ALU; alu_fn = FN_SLT;  use_imm = 1'b1; end
            OP_SLTIU: begin op_class = CLS_ALU; alu_fn = FN_SLTU; use_imm = 1'b1; end
            OP_XORI:  begin op_class = CLS_ALU; alu_fn = FN_XOR;  use_imm = 1'b1; end
            OP_ORI:   begin op_class = CLS_ALU; alu_fn = FN_OR;   use_imm = 1'b1; end
            OP_ANDI:  begin op_class = CLS_ALU; alu_fn = FN_AND;  use_imm = 1'b1; end
            OP_SLLI:  begin op_class = CLS_ALU; alu_fn = FN_SLL;  use_imm = 1'b1; end
            OP_SRLI:  begin op_class = CLS_ALU; alu_fn = FN_SRL;  use_imm = 1'b1; end
            OP_SRAI:  begin op_class = CLS_ALU; alu_fn = FN_SRA;  use_imm = 1'b1; end
            OP_LUI:   begin op_class = CLS_ALU; alu_fn = FN_PASS_B; use_imm = 1'b1; end
            OP_AUIPC: op_class = CLS_AUIPC;
            OP_JAL:   op_class = CLS_JAL;
            OP_JALR:  op_class = CLS_JALR;
            OP_BEQ:   begin op_class = CLS_BRANCH; br_cond = BR_EQ;  end
            OP_BNE:   begin op_class = CLS_BRANCH; br_cond = BR_NE;  end
            OP_BLT:   begin op_class = CLS_BRANCH; br_cond = BR_LT;  end
            OP_BGE:   begin op_class = CLS_BRANCH; br_cond = BR_GE;  end
            OP_BLTU:  begin op_class = CLS_BRANCH; br_cond = BR_LTU; end
            OP_BGEU:  begin op_class = CLS_BRANCH; br_cond = BR_GEU; end
            default:  op_class = CLS_BAD;
        endcase
    end

    assign alu_b = use_imm ? FU_Imm : FU_Vk;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_out = 32'd0;
        case (alu_fn)
            FN_ADD:    alu_out = FU_Vj + alu_b;
            FN_SUB:    alu_out = FU_Vj - alu_b;
            FN_SLL:    alu_out = FU_Vj << shamt;
            FN_SLT:    alu_out = {31'd0, $signed(FU_Vj) < $signed(alu_b)};
            FN_SLTU:   alu_out = {31'd0, FU_Vj < alu_b};
            FN_XOR:    alu_out = FU_Vj ^ alu_b;
            FN_SRL:    alu_out = FU_Vj >> shamt;
            FN_SRA:    alu_out = $unsigned($signed(FU_Vj) >>> shamt);
            FN_OR:     alu_out = FU_Vj | alu_b;
            FN_AND:    alu_out = FU_Vj & alu_b;
            FN_PASS_B: alu_out = alu_b;
            default:   alu_out = 32'd0;
        endcase
    end

    assign pc_plus4    = FU_CurPC + 32'd4;
    assign pc_plus_imm = FU_CurPC + FU_Imm;
    assign jalr_sum    = FU_Vj + FU_Imm;

    // Branches always compare the two register operands, never the immediate.
    assign br_eq   = (FU_Vj == FU_Vk);
    assign br_lt_s = ($signed(FU_Vj) < $signed(FU_Vk));
    assign br_lt_u = (FU_Vj < FU_Vk);

    always_comb begin
        br_taken = 1'b0;
        case (br_cond)
            BR_EQ:   br_taken = br_eq;
            BR_NE:   br_taken = !br_eq;
            BR_LT:   br_taken = br_lt_s;
            BR_GE:   br_taken = !br_lt_s;
            BR_LTU:  br_taken = br_lt_u;
            BR_GEU:  br_taken = !br_lt_u;
            default: br_taken = 1'b0;
        endcase
    end

    // Unknown ops still produce a result so the ROB entry can retire.
    always_comb begin
        nxt_value  = 32'd0;
        nxt_jump   = 1'b0;
        nxt_target = pc_plus4;
        case (op_class)
            CLS_ALU:   nxt_value = alu_out;
            CLS_AUIPC: nxt_value = pc_plus_imm;
            CLS_JAL: begin
                nxt_value  = pc_plus4;
                nxt_jump   = 1'b1;
                nxt_target = pc_plus_imm;
            end
            CLS_JALR: begin
                nxt_value  = pc_plus4;
                nxt_jump   = 1'b1;
                nxt_target = jalr_sum & 32'hFFFF_FFFE;
            end
            CLS_BRANCH: begin
                nxt_jump   = br_taken;
                nxt_target = br_taken ? pc_plus_imm : pc_plus4;
            end
            default: begin
                nxt_value  = 32'd0;
                nxt_jump   = 1'b0;
                nxt_target = pc_plus4;
            end
        endcase
    end

    // Data outputs only change on an accepted issue; exc_valid is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_valid  <= 1'b0;
            exc_RobId  <= '0;
            exc_value  <= 32'd0;
            exc_jump   <= 1'b0;
            exc_target <= 32'd0;
        end else if (jump_flag) begin
            exc_valid <= 1'b0;
        end else if (!rdy) begin
            exc_valid <= 1'b0;
        end else if (FU_enable) begin
            exc_valid  <= 1'b1;
            exc_RobId  <= FU_DestRob;
            exc_value  <= nxt_value;
            exc_jump   <= nxt_jump;
            exc_target <= nxt_target;
        end else begin
            exc_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execution unit on the issue-to-FU path. It consumes one ready instruction per cycle from the reservation station's FU_* outputs.
- It computes the RV32I ALU, branch and jump result and broadcasts it one cycle later on the exc_* result bus.
- The RS, LSB and ROB snoop that bus. The ROB also takes the branch-resolution fields for commit-time redirect.

Parameters:
- OP_LOG, config macro, width of the op encoding (op names from config.v).
- ROB_LOG, config macro, width of a ROB index.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; low = stall
- jump_flag  in  1  pipeline flush
- FU_enable  in  1  issue strobe, one instruction per cycle, no backpressure
- FU_op  in  OP_LOG  operation
- FU_Vj  in  32  rs1 value
- FU_Vk  in  32  rs2 value
- FU_Imm  in  32  sign/zero-extended immediate, already positioned by the decoder
- FU_DestRob  in  ROB_LOG  destination ROB entry
- FU_CurPC  in  32  PC of the instruction
- exc_valid  out  1  result broadcast valid
- exc_RobId  out  ROB_LOG  ROB entry of the result
- exc_value  out  32  rd write value
- exc_jump  out  1  control transfer taken
- exc_target  out  32  actual next PC

Behaviour:
- All outputs are registers on posedge clk, cleared asynchronously by posedge rst. Reset values: exc_valid=0, exc_RobId=0, exc_value=0, exc_jump=0, exc_target=0.
- Priority per edge:
  - rst.
  - jump_flag: exc_valid<=0, issue input ignored.
  - ~rdy: exc_valid<=0, data outputs hold.
  - FU_enable: compute and register the result, exc_valid<=1.
  - Otherwise exc_valid<=0, data outputs hold.
- Latency: result is visible exactly 1 cycle after the edge that samples FU_enable=1. Throughput is 1 per cycle; back-to-back issues give back-to-back exc_valid.
- exc_RobId<=FU_DestRob on every accepted issue.
- R-type (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND) use Vj op Vk.
- I-type (ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI) use Vj op Imm.
- Shifts use only bits [4:0] of the second operand. SRA/SRAI are arithmetic; SLT is signed; SLTU is unsigned. All adds wrap mod 2^32.
- LUI: value=Imm. AUIPC: value=PC+Imm.
- For all non-control ops: exc_jump=0, exc_target=PC+4.
- JAL: value=PC+4, jump=1, target=PC+Imm.
- JALR: value=PC+4, jump=1, target=(Vj+Imm)&~1.
- Branches (BEQ BNE BLT BGE BLTU BGEU) compare Vj with Vk, signed or unsigned per op.
  - Taken: jump=1, target=PC+Imm.
  - Not taken: jump=0, target=PC+4.
  - value=0 in both cases.
- Unknown op: exc_valid=1, value=0, jump=0, target=PC+4. The instruction is never dropped silently.
- jump_flag in the same cycle as FU_enable discards that instruction. A result already registered before the flush edge is still visible for its one cycle.
- rst asserted mid-stream clears exc_valid immediately (asynchronous), without waiting for a clock.
- No internal state other than the output registers. The block must not hold a result across two cycles with exc_valid=1.

Test Plan:
- Reset, then ADD with Vj=0x7FFFFFFF, Vk=1, DestRob=5. Required: next cycle exc_valid=1, RobId=5, value=0x80000000, jump=0, target=PC+4. The cycle after: exc_valid=0.
- Shifts and compares.
  - SRA Vj=0x80000000, Vk=0x24: value=0xF8000000 (only shift-amount bits [4:0] are used).
  - SLTU Vj=1, Vk=0xFFFFFFFF: value=1.
  - SLT with the same operands: value=0.
- Branches at PC=0x100, Imm=0x20.
  - BLT Vj=0xFFFFFFFF, Vk=0: jump=1, target=0x120.
  - BGEU with the same operands: jump=1, target=0x120.
  - BEQ Vj=1, Vk=2: jump=0, target=0x104.
- JALR at PC=0x200, Vj=0x1001, Imm=4: value=0x204, jump=1, target=0x1004. JAL with Imm=-8: target=0x1F8.
- Three back-to-back issues with ROB ids 1,2,3 and jump_flag asserted on the third issue's cycle. Required: ids 1 and 2 appear on consecutive cycles, and id 3 never appears.
- rdy=0 on an issue cycle: exc_valid=0 and data outputs unchanged. Asynchronous rst pulse between clock edges: all outputs read 0 before the next edge.
